// File: rtl/rv32i_pkg.sv
// Shared RV32I decode constants and the decoded-entry bundle that
// travels from the issue stage to execute.
package rv32i_pkg;

  localparam int DATA_W = 32;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  // ALU control codes; these match the case items of the execute ALU.
  // 4'b0101 and 4'b0110 are deliberately unused.
  localparam logic [3:0] ALU_CTRL_ADD  = 4'b0000;
  localparam logic [3:0] ALU_CTRL_SLT  = 4'b0001;
  localparam logic [3:0] ALU_CTRL_SLTU = 4'b0010;
  localparam logic [3:0] ALU_CTRL_XOR  = 4'b0011;
  localparam logic [3:0] ALU_CTRL_OR   = 4'b0100;
  localparam logic [3:0] ALU_CTRL_AND  = 4'b0111;
  localparam logic [3:0] ALU_CTRL_SLL  = 4'b1000;
  localparam logic [3:0] ALU_CTRL_SRL  = 4'b1001;
  localparam logic [3:0] ALU_CTRL_SRA  = 4'b1010;
  localparam logic [3:0] ALU_CTRL_SUB  = 4'b1011;

  // funct7 values: base encoding and the alternate (SUB/SRA) encoding
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Decoded entry handed to execute
  typedef struct packed {
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] store_data;
    logic [3:0]        alu_ctrl;
    logic [4:0]        rd;
    logic              reg_write;
    logic              is_branch;
    logic [2:0]        br_funct3;
    logic              is_load;
    logic              is_store;
    logic              illegal;
  } dec_t;

  localparam int DEC_W = $bits(dec_t);

  // Base funct3 -> ALU control map shared by OP and OP-IMM
  function automatic logic [3:0] f3_to_ctrl(input logic [2:0] f3);
    logic [3:0] ctrl;
    ctrl = ALU_CTRL_ADD;
    case (f3)
      3'b000: ctrl = ALU_CTRL_ADD;
      3'b001: ctrl = ALU_CTRL_SLL;
      3'b010: ctrl = ALU_CTRL_SLT;
      3'b011: ctrl = ALU_CTRL_SLTU;
      3'b100: ctrl = ALU_CTRL_XOR;
      3'b101: ctrl = ALU_CTRL_SRL;
      3'b110: ctrl = ALU_CTRL_OR;
      3'b111: ctrl = ALU_CTRL_AND;
      default: ctrl = ALU_CTRL_ADD;
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Bundle of the issue stage's upstream (fetch/regfile) and downstream
// (execute) handshakes. The stage uses the slave view; the surrounding
// pipeline (or a bench) uses the master view.
interface alu_issue_stage_if;
  import rv32i_pkg::*;

  // Upstream side
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_instr;
  logic [DATA_W-1:0] in_pc;
  logic [DATA_W-1:0] in_rs1;
  logic [DATA_W-1:0] in_rs2;

  // Downstream side
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [3:0]        alu_ctrl;
  logic [DATA_W-1:0] store_data;
  logic [4:0]        rd;
  logic              reg_write;
  logic              is_branch;
  logic [2:0]        br_funct3;
  logic              is_load;
  logic              is_store;
  logic              illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, in_rs1, in_rs2, out_ready,
    output in_ready, out_valid, alu_a, alu_b, alu_ctrl, store_data, rd,
           reg_write, is_branch, br_funct3, is_load, is_store, illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, in_rs1, in_rs2, out_ready,
    input  in_ready, out_valid, alu_a, alu_b, alu_ctrl, store_data, rd,
           reg_write, is_branch, br_funct3, is_load, is_store, illegal
  );

endinterface

// File: rtl/alu_decode.sv
// Purely combinational RV32I decoder: forms ALU operands (including
// immediates), the ALU control code and the side-band flags.
module alu_decode
  import rv32i_pkg::*;
(
  input  logic [DATA_W-1:0] instr,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] rs1,
  input  logic [DATA_W-1:0] rs2,
  output dec_t              dec
);

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [DATA_W-1:0] imm_i;
  logic [DATA_W-1:0] imm_s;
  logic [DATA_W-1:0] imm_u;
  logic [DATA_W-1:0] shamt;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_u  = {instr[31:12], 12'b0};
  assign shamt  = {27'b0, instr[24:20]};

  // Opcode decode, operand selection and legality checks
  always_comb begin
    // NOTE: every field gets a default before the case so no path leaves a
    // field unassigned; otherwise synthesis infers a latch.
    dec            = '0;
    dec.alu_ctrl   = ALU_CTRL_ADD;
    dec.rd         = instr[11:7];
    dec.store_data = rs2;

    case (opcode)
      OP: begin
        dec.alu_a     = rs1;
        dec.alu_b     = rs2;
        dec.reg_write = 1'b1;
        if (funct7 == F7_BASE)                          dec.alu_ctrl = f3_to_ctrl(funct3);
        else if (funct7 == F7_ALT && funct3 == 3'b000)  dec.alu_ctrl = ALU_CTRL_SUB;
        else if (funct7 == F7_ALT && funct3 == 3'b101)  dec.alu_ctrl = ALU_CTRL_SRA;
        else                                            dec.illegal  = 1'b1;
      end
      OP_IMM: begin
        dec.alu_a     = rs1;
        dec.alu_b     = imm_i;
        dec.reg_write = 1'b1;
        dec.alu_ctrl  = f3_to_ctrl(funct3);
        if (funct3 == 3'b001) begin
          dec.alu_b = shamt;
          if (funct7 != F7_BASE) dec.illegal = 1'b1;
        end else if (funct3 == 3'b101) begin
          dec.alu_b = shamt;
          if (funct7 == F7_ALT)       dec.alu_ctrl = ALU_CTRL_SRA;
          else if (funct7 != F7_BASE) dec.illegal  = 1'b1;
        end
      end
      LUI: begin
        dec.alu_b     = imm_u;
        dec.reg_write = 1'b1;
      end
      AUIPC: begin
        dec.alu_a     = pc;
        dec.alu_b     = imm_u;
        dec.reg_write = 1'b1;
      end
      LOAD: begin
        dec.alu_a     = rs1;
        dec.alu_b     = imm_i;
        dec.is_load   = 1'b1;
        dec.reg_write = 1'b1;
      end
      STORE: begin
        dec.alu_a    = rs1;
        dec.alu_b    = imm_s;
        dec.is_store = 1'b1;
      end
      BRANCH: begin
        dec.alu_a     = rs1;
        dec.alu_b     = rs2;
        dec.is_branch = 1'b1;
        dec.br_funct3 = funct3;
        case (funct3)
          3'b000, 3'b001: dec.alu_ctrl = ALU_CTRL_SUB;   // BEQ/BNE use zero flag
          3'b100, 3'b101: dec.alu_ctrl = ALU_CTRL_SLT;
          3'b110, 3'b111: dec.alu_ctrl = ALU_CTRL_SLTU;
          default:        dec.illegal  = 1'b1;
        endcase
      end
      JAL, JALR: begin
        // Link value pc+4; target computation lives elsewhere
        dec.alu_a     = pc;
        dec.alu_b     = 32'd4;
        dec.reg_write = 1'b1;
        if (opcode == JALR && funct3 != 3'b000) dec.illegal = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase

    // Illegal entries still flow to execute so it can trap, but must not
    // have any architectural side effect.
    if (dec.illegal) begin
      dec.alu_ctrl  = ALU_CTRL_ADD;
      dec.reg_write = 1'b0;
      dec.is_branch = 1'b0;
      dec.is_load   = 1'b0;
      dec.is_store  = 1'b0;
    end

    if (dec.rd == 5'd0) dec.reg_write = 1'b0;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage toward the ALU: decodes the incoming instruction and holds
// it in a 2-entry skid buffer (head + skid) so in_ready can be registered.
module alu_issue_stage
  import rv32i_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SKID_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  alu_issue_stage_if.slave   io
);

  localparam int CNT_W = $clog2(SKID_DEPTH + 1);

  if (XLEN != 32 || SKID_DEPTH != 2) begin : g_unsupported
    $error("alu_issue_stage supports only XLEN=32 and SKID_DEPTH=2");
  end

  dec_t             dec;
  dec_t             head_q, head_d;
  dec_t             skid_q, skid_d;
  logic             head_vld_q, head_vld_d;
  logic             skid_vld_q, skid_vld_d;
  logic             in_ready_q, in_ready_d;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] count_d;

  alu_decode u_decode (
    .instr (io.in_instr),
    .pc    (io.in_pc),
    .rs1   (io.in_rs1),
    .rs2   (io.in_rs2),
    .dec   (dec)
  );

  assign push = io.in_valid & in_ready_q;
  assign pop  = head_vld_q & io.out_ready;

  // Skid-buffer next state; the head only changes on a pop, a fill from
  // empty, or flush, which keeps outputs stable under backpressure.
  always_comb begin
    head_d     = head_q;
    skid_d     = skid_q;
    head_vld_d = head_vld_q;
    skid_vld_d = skid_vld_q;

    if (flush) begin
      head_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!head_vld_q) begin
      if (push) begin
        head_d     = dec;
        head_vld_d = 1'b1;
      end
    end else if (!skid_vld_q) begin
      if (pop && push) begin
        head_d = dec;
      end else if (pop) begin
        head_vld_d = 1'b0;
      end else if (push) begin
        skid_d     = dec;
        skid_vld_d = 1'b1;
      end
    end else if (pop) begin
      // Full: in_ready is low, so only the skid-to-head move can happen
      head_d     = skid_q;
      skid_vld_d = 1'b0;
    end

    count_d    = CNT_W'(head_vld_d) + CNT_W'(skid_vld_d);
    in_ready_d = (count_d != CNT_W'(SKID_DEPTH));
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the entry registers are reset as well as the valid bits because
      // the data outputs must read zero out of reset; it costs only a reset
      // pin on each data flop.
      head_q     <= '0;
      skid_q     <= '0;
      head_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values
      // regardless of statement order.
      head_q     <= head_d;
      skid_q     <= skid_d;
      head_vld_q <= head_vld_d;
      skid_vld_q <= skid_vld_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign io.in_ready   = in_ready_q;
  assign io.out_valid  = head_vld_q;
  assign io.alu_a      = head_q.alu_a;
  assign io.alu_b      = head_q.alu_b;
  assign io.alu_ctrl   = head_q.alu_ctrl;
  assign io.store_data = head_q.store_data;
  assign io.rd         = head_q.rd;
  assign io.reg_write  = head_q.reg_write;
  assign io.is_branch  = head_q.is_branch;
  assign io.br_funct3  = head_q.br_funct3;
  assign io.is_load    = head_q.is_load;
  assign io.is_store   = head_q.is_store;
  assign io.illegal    = head_q.illegal;

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Pipeline stage that drives the ALU's operand and control interface.
- Takes a fetched RV32I instruction, its PC and the register-file read data. Decodes the instruction to the 4-bit ALU control code, selects and forms operands a/b (including immediate generation), and registers the result toward execute.
- Valid/ready handshake on both sides, with a 2-entry skid buffer so that in_ready is a registered signal.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.
- SKID_DEPTH, 2, output buffer entries. Only 2 is supported.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of all buffered entries.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept an entry.
- in_instr  in  32  instruction word.
- in_pc  in  32  instruction address.
- in_rs1  in  32  rs1 read data.
- in_rs2  in  32  rs2 read data.
- out_valid  out  1  issued entry valid.
- out_ready  in  1  execute accepts the entry.
- alu_a  out  32  ALU operand a.
- alu_b  out  32  ALU operand b.
- alu_ctrl  out  4  ALU control code.
- store_data  out  32  rs2 pass-through for stores.
- rd  out  5  destination register.
- reg_write  out  1  write-back enable.
- is_branch  out  1  conditional branch.
- br_funct3  out  3  branch condition.
- is_load  out  1  load.
- is_store  out  1  store.
- illegal  out  1  unsupported or illegal encoding.

Behaviour:
- Reset (rst_n low, asynchronous): both buffer entries invalid; out_valid=0; in_ready=1. All data outputs are 0, and alu_ctrl=4'b0000.
- Handshakes: an input transfer occurs when in_valid&in_ready; an output transfer occurs when out_valid&out_ready. Latency is 1 cycle from input transfer to out_valid. Throughput is 1 entry per cycle while out_ready=1.
- Output-hold rule: while out_valid=1 and out_ready=0, all outputs are held stable.
- in_ready = !(entry count == 2). It is a registered signal with no combinational path from out_ready.
- Skid buffer:
  - Count 0: an accepted entry goes to the head register.
  - Count 1: an accepted entry goes to the head register only if the head is transferring in the same cycle; otherwise it goes to the skid register.
  - Count 2: on a head transfer, the skid entry moves to the head.
- Flush: the next state is empty and out_valid=0. An input accepted in the same cycle as flush is discarded, because flush has priority.
- Control codes (alu_ctrl):
  - ADD 0000, SLT 0001, SLTU 0010, XOR 0011, OR 0100, AND 0111.
  - SLL 1000, SRL 1001, SRA 1010, SUB 1011.
  - Codes 0101 and 0110 are never emitted.
- OP (0110011): a=rs1, b=rs2, reg_write=1.
  - funct7=0000000 selects by funct3: 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
  - funct7=0100000 with funct3 000 is SUB; with funct3 101 is SRA.
  - Any other funct7/funct3 combination is illegal.
- OP-IMM (0010011): a=rs1, b=sign-extended imm[31:20], same funct3 map as OP.
  - SLLI and SRLI require imm[11:5]=0000000; SRAI requires imm[11:5]=0100000. Otherwise illegal.
  - For shifts, b={27'b0,shamt}.
- LUI: a=0, b={instr[31:12],12'b0}, ADD.
- AUIPC: a=pc, b={instr[31:12],12'b0}, ADD.
- LOAD: a=rs1, b=I-imm, ADD, is_load=1, reg_write=1.
- STORE: a=rs1, b=S-imm, ADD, is_store=1, store_data=rs2, reg_write=0.
- BRANCH: a=rs1, b=rs2, is_branch=1, br_funct3=funct3.
  - BEQ/BNE issue SUB; execute uses the ALU zero flag.
  - BLT/BGE issue SLT; BLTU/BGEU issue SLTU.
  - funct3 010 or 011 is illegal.
- JAL: a=pc, b=32'd4, ADD, reg_write=1. This computes the link value.
- JALR: a=pc, b=32'd4, ADD, reg_write=1. funct3 must be 000, otherwise illegal.
- Illegal or unknown opcode: illegal=1, alu_ctrl=ADD, reg_write=is_branch=is_load=is_store=0. The entry still flows through the stage so that execute can trap.
- rd=instr[11:7] for all instructions. reg_write=0 when rd=0.
- Reset asserted mid-stream: entries are lost immediately and the stage recovers with in_ready=1.

Decomposition:
- rv32i_pkg holds:
  - Opcode localparams: OP, OP_IMM, LUI, AUIPC, LOAD, STORE, BRANCH, JAL, JALR.
  - ALU_CTRL_* codes (matching the ALU case items).
  - funct7 constants.
  - Decoded-entry bundle width.
- One sub-module: alu_decode. It is purely combinational: instr, pc, rs1, rs2 in; decoded bundle out, with immediate generation inside.
- alu_issue_stage contains only the skid buffer and the handshake logic.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7, out_ready=1 -> next cycle: out_valid=1, a=5, b=7, ctrl=0000, rd=3, reg_write=1.
- SRAI x5,x6,4 (0x40435293), rs1=0xF0000000 -> ctrl=1010, b=4. Same with imm[11:5]=0100001 -> illegal=1, reg_write=0.
- Backpressure: stream 3 entries with out_ready=0 -> entries 1 and 2 accepted; in_ready falls after the 2nd; outputs stay stable. Release out_ready -> entries emerge in order 1, 2, 3 with no loss or duplication.
- BLTU x1,x2 (0x0020E463) -> ctrl=0010, is_branch=1, br_funct3=110, a=rs1, b=rs2, reg_write=0.
- LUI x1,0x12345 (0x123450B7) -> a=0, b=0x12345000, ctrl=0000. SW with imm=-4 -> b=0xFFFFFFFC, is_store=1, store_data=rs2.
- Flush with 2 entries buffered and in_valid=1 in the same cycle -> next cycle: out_valid=0, in_ready=1, no entry emitted. rst_n pulse mid-stream -> out_valid=0 asynchronously.
